// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the dot-product pipeline.
// The extend helper works on a fixed wide vector so any operand width can use it.
package dot_product_pkg;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_ACC    = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e mode;
    logic  close;
    logic  trunc;
  } beat_tag_t;

  localparam int TAG_W = $bits(beat_tag_t);
  localparam int EXT_W = 128;

  function automatic int tree_depth(input int num_pairs);
    return $clog2(num_pairs);
  endfunction

  function automatic int out_w(input int data_w, input int num_pairs, input int max_beats);
    return 2 * data_w + $clog2(num_pairs) + $clog2(max_beats);
  endfunction

  function automatic int latency(input int num_pairs);
    return 2 + tree_depth(num_pairs);
  endfunction

  // Treat the low w bits of v as the value; fill the rest with zeros or the sign bit.
  function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] v, input int w,
                                              input logic sgn);
    logic [EXT_W-1:0] mask;
    logic             msb;
    mask = {EXT_W{1'b1}} << w;
    msb  = |(v & ({{(EXT_W-1){1'b0}}, 1'b1} << (w - 1)));
    return (sgn && msb) ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered adder-tree level: sums adjacent operand pairs, growing one bit,
// and carries the beat's valid bit and tag alongside the data.
module add_tree_level
  import dot_product_pkg::*;
#(
  parameter int IN_N   = 2,
  parameter int IN_W   = 16,
  parameter int TAG_W  = 3,
  parameter int SIGNED = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              advance,
  input  logic                              in_valid,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic [IN_N*IN_W-1:0]              in_data,
  output logic                              out_valid,
  output logic [TAG_W-1:0]                  out_tag,
  output logic [(IN_N/2)*(IN_W+1)-1:0]      out_data
);

  localparam int SUM_N = IN_N / 2;
  localparam int SUM_W = IN_W + 1;
  localparam logic SGN = (SIGNED != 0);

  logic [SUM_N*SUM_W-1:0] sum_next;

  genvar gi;
  generate
    for (gi = 0; gi < SUM_N; gi++) begin : g_pair
      logic [SUM_W-1:0] lo_ext;
      logic [SUM_W-1:0] hi_ext;
      assign lo_ext = SUM_W'(extend(EXT_W'(in_data[(2*gi)*IN_W +: IN_W]), IN_W, SGN));
      assign hi_ext = SUM_W'(extend(EXT_W'(in_data[(2*gi+1)*IN_W +: IN_W]), IN_W, SGN));
      assign sum_next[gi*SUM_W +: SUM_W] = lo_ext + hi_ext;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_tag   <= in_tag;
      out_data  <= sum_next;
    end
  end

endmodule

// File: rtl/dot_product_pipe.sv
// Pipelined sum-of-products: product register, registered adder tree, then an
// output/accumulate stage with burst accumulation and valid/ready handshakes.
module dot_product_pipe
  import dot_product_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PAIRS = 2,
  parameter int MAX_BEATS = 16,
  parameter int SIGNED    = 0,
  localparam int OUT_W    = out_w(DATA_W, NUM_PAIRS, MAX_BEATS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        acc_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_PAIRS*DATA_W-1:0] in_a,
  input  logic [NUM_PAIRS*DATA_W-1:0] in_b,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_trunc
);

  localparam int   PW    = 2 * DATA_W;
  localparam int   DEPTH = tree_depth(NUM_PAIRS);
  localparam int   SUM_W = PW + DEPTH;
  localparam int   CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic SGN   = (SIGNED != 0);

  logic advance;
  logic accept;

  assign advance  = en && !(out_valid && !out_ready);
  assign in_ready = rst && advance;
  assign accept   = in_valid && in_ready;

  // Operands are widened to product width first so the low product bits are
  // correct for both signed and unsigned interpretation.
  logic [NUM_PAIRS*PW-1:0] prod_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_mul
      logic [PW-1:0] a_ext;
      logic [PW-1:0] b_ext;
      assign a_ext = PW'(extend(EXT_W'(in_a[gi*DATA_W +: DATA_W]), DATA_W, SGN));
      assign b_ext = PW'(extend(EXT_W'(in_b[gi*DATA_W +: DATA_W]), DATA_W, SGN));
      assign prod_next[gi*PW +: PW] = a_ext * b_ext;
    end
  endgenerate

  logic               burst_open_reg;
  mode_e              mode_reg;
  logic [CNT_W-1:0]   cnt_reg;
  mode_e              beat_mode;
  logic               at_max;
  beat_tag_t          beat_tag;

  // Burst bookkeeping happens at accept time so the tag travels with the beat.
  always_comb begin
    beat_mode      = burst_open_reg ? mode_reg : mode_e'(acc_mode);
    at_max         = (cnt_reg == CNT_W'(MAX_BEATS - 1));
    beat_tag.mode  = beat_mode;
    beat_tag.close = in_last || at_max;
    beat_tag.trunc = (MAX_BEATS > 1) && at_max && !in_last;
  end

  logic                    prod_valid_reg;
  logic [NUM_PAIRS*PW-1:0] prod_reg;
  beat_tag_t               prod_tag_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_valid_reg <= 1'b0;
      prod_reg       <= '0;
      prod_tag_reg   <= '0;
      burst_open_reg <= 1'b0;
      mode_reg       <= MODE_SINGLE;
      cnt_reg        <= '0;
    end else if (advance) begin
      prod_valid_reg <= accept;
      if (accept) begin
        prod_reg     <= prod_next;
        prod_tag_reg <= beat_tag;
        if (beat_mode == MODE_ACC) begin
          if (beat_tag.close) begin
            burst_open_reg <= 1'b0;
            cnt_reg        <= '0;
          end else begin
            burst_open_reg <= 1'b1;
            mode_reg       <= beat_mode;
            cnt_reg        <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
      localparam int N_IN = NUM_PAIRS >> gi;
      localparam int W_IN = PW + gi;
      logic                           valid;
      logic [TAG_W-1:0]               tag;
      logic [(N_IN/2)*(W_IN+1)-1:0]   data;
      if (gi == 0) begin : g_first
        add_tree_level #(
          .IN_N(N_IN), .IN_W(W_IN), .TAG_W(TAG_W), .SIGNED(SIGNED)
        ) u_level (
          .clk(clk), .rst(rst), .advance(advance),
          .in_valid(prod_valid_reg), .in_tag(prod_tag_reg), .in_data(prod_reg),
          .out_valid(valid), .out_tag(tag), .out_data(data)
        );
      end else begin : g_next
        add_tree_level #(
          .IN_N(N_IN), .IN_W(W_IN), .TAG_W(TAG_W), .SIGNED(SIGNED)
        ) u_level (
          .clk(clk), .rst(rst), .advance(advance),
          .in_valid(g_lvl[gi-1].valid), .in_tag(g_lvl[gi-1].tag),
          .in_data(g_lvl[gi-1].data),
          .out_valid(valid), .out_tag(tag), .out_data(data)
        );
      end
    end
  endgenerate

  logic             tree_valid;
  beat_tag_t        tree_tag;
  logic [SUM_W-1:0] tree_sum;
  logic [OUT_W-1:0] sum_ext;
  logic [OUT_W-1:0] acc_reg;

  assign tree_valid = g_lvl[DEPTH-1].valid;
  assign tree_tag   = beat_tag_t'(g_lvl[DEPTH-1].tag);
  assign tree_sum   = g_lvl[DEPTH-1].data;
  assign sum_ext    = OUT_W'(extend(EXT_W'(tree_sum), SUM_W, SGN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_trunc <= 1'b0;
      acc_reg   <= '0;
    end else if (advance) begin
      out_valid <= 1'b0;
      if (tree_valid) begin
        if (tree_tag.mode == MODE_SINGLE) begin
          out_valid <= 1'b1;
          out_data  <= sum_ext;
          out_trunc <= 1'b0;
        end else if (tree_tag.close) begin
          out_valid <= 1'b1;
          out_data  <= acc_reg + sum_ext;
          out_trunc <= tree_tag.trunc;
          acc_reg   <= '0;
        end else begin
          acc_reg <= acc_reg + sum_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_pipe.sv
// Self-checking bench: directed scenarios plus randomized back-to-back traffic,
// scored against a beat-level arithmetic model of the sum-of-products engine.
module tb_dot_product_pipe;

  localparam int OW = 21;
  localparam int MB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, acc_mode, in_valid, in_last, out_ready, s_valid;
  logic [15:0]   in_a, in_b;
  logic          in_ready, out_valid, out_trunc;
  logic [OW-1:0] out_data;
  logic          s_ready, s_out_valid, s_out_trunc;
  logic [OW-1:0] s_out_data;
  logic          s_out_ready = 1'b1;

  dot_product_pipe #(.DATA_W(8), .NUM_PAIRS(2), .MAX_BEATS(16), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .en(en), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_trunc(out_trunc)
  );

  dot_product_pipe #(.DATA_W(8), .NUM_PAIRS(2), .MAX_BEATS(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .acc_mode(acc_mode),
    .in_valid(s_valid), .in_ready(s_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_trunc(s_out_trunc)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: expected results in order, plus open-burst bookkeeping.
  longint        exp_data[$];
  bit            exp_trunc[$];
  bit            m_in_burst = 0;
  bit            m_mode = 0;
  int            m_cnt = 0;
  longint        m_sum = 0;

  int            out_count = 0;
  longint        last_out = 0;
  bit            last_trunc = 0;
  bit            accepted = 0;
  bit            hold_pend = 0;
  logic [OW-1:0] held_data;
  logic          held_trunc;

  function automatic longint beat_sum(input logic [15:0] a, input logic [15:0] b);
    return longint'(a[7:0]) * longint'(b[7:0]) + longint'(a[15:8]) * longint'(b[15:8]);
  endfunction

  task automatic model_reset();
    exp_data.delete();
    exp_trunc.delete();
    m_in_burst = 0;
    m_mode = 0;
    m_cnt = 0;
    m_sum = 0;
    hold_pend = 0;
  endtask

  task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input bit mode,
                            input bit last);
    longint s;
    s = beat_sum(a, b);
    if (!m_in_burst) m_mode = mode;
    if (!m_mode) begin
      exp_data.push_back(s);
      exp_trunc.push_back(1'b0);
    end else begin
      m_sum += s;
      m_cnt++;
      if (last || m_cnt == MB) begin
        exp_data.push_back(m_sum);
        exp_trunc.push_back(!last && m_cnt == MB);
        m_sum = 0;
        m_cnt = 0;
        m_in_burst = 0;
      end else begin
        m_in_burst = 1;
      end
    end
  endtask

  // Drive one cycle (called just after an edge), score what happens at the next edge.
  task automatic run_cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                           input bit mode, input bit last, input bit ordy, input bit e);
    logic [OW-1:0] ev;
    bit            et;
    in_valid = v; in_a = a; in_b = b; acc_mode = mode; in_last = last;
    out_ready = ordy; en = e;
    #1;
    if (hold_pend) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_trunc !== held_trunc)
        begin
          failures++;
          $display("FAIL hold_stable: got valid=%b data=%0d trunc=%b, want valid=1 data=%0d trunc=%b",
                   out_valid, out_data, out_trunc, held_data, held_trunc);
        end
    end
    hold_pend  = rst && out_valid && !out_ready;
    held_data  = out_data;
    held_trunc = out_trunc;
    if (rst) begin
      checks++;
      if (in_ready !== (e && !(out_valid && !ordy))) begin
        failures++;
        $display("FAIL in_ready: got %b want %b", in_ready, e && !(out_valid && !ordy));
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      out_count++;
      last_out = longint'(out_data);
      last_trunc = out_trunc;
      $display("out %0d data=%0d trunc=%0b", out_count, out_data, out_trunc);
      if (exp_data.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got data=%0d, want no output", out_data);
      end else begin
        ev = OW'(exp_data.pop_front());
        et = exp_trunc.pop_front();
        if (out_data !== ev || out_trunc !== et) begin
          failures++;
          $display("FAIL result: got data=%0d trunc=%b, want data=%0d trunc=%b",
                   out_data, out_trunc, ev, et);
        end
      end
    end
    accepted = (in_valid && in_ready === 1'b1);
    if (accepted) model_beat(a, b, mode, last);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (i < 6 || exp_data.size() != 0 || out_valid === 1'b1); i++)
      run_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (exp_data.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still pending, want 0", exp_data.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_trunc !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%0d trunc=%b ready=%b, want all 0",
               out_valid, out_data, out_trunc, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b/%b want 1/1", in_ready, s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    run_cycle(1'b1, {8'd4, 8'd3}, {8'd6, 8'd5}, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (!accepted || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_stage1: accepted=%b valid=%b, want 1/0", accepted, out_valid);
    end
    run_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_stage2: valid=%b want 0", out_valid);
    end
    // Third register stage: result is visible after the second edge past the accept edge.
    run_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 21'd39) begin
      failures++;
      $display("FAIL lat_result: valid=%b data=%0d, want 1/39", out_valid, out_data);
    end
    run_cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    checks++;
    if (last_out != 130050) begin
      failures++;
      $display("FAIL max_unsigned: got %0d want 130050", last_out);
    end
  endtask

  task automatic test_signed();
    int ta0[2] = '{-3, -128};
    int ta1[2] = '{4, -128};
    int tb0[2] = '{5, -128};
    int tb1[2] = '{6, 127};
    int expv;
    int n;
    for (int k = 0; k < 2; k++) begin
      in_a = {8'(ta1[k]), 8'(ta0[k])};
      in_b = {8'(tb1[k]), 8'(tb0[k])};
      in_valid = 1'b0; acc_mode = 1'b0; in_last = 1'b0; en = 1'b1; s_valid = 1'b1;
      expv = ta0[k] * tb0[k] + ta1[k] * tb1[k];
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      n = 0;
      while (n < 8 && s_out_valid !== 1'b1) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (s_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL signed_timeout: no result for case %0d", k);
      end else if (int'($signed(s_out_data)) != expv || s_out_trunc !== 1'b0) begin
        failures++;
        $display("FAIL signed_result: case %0d got %0d trunc=%b want %0d trunc=0",
                 k, $signed(s_out_data), s_out_trunc, expv);
      end
      $display("signed %0d data=%0d", k, $signed(s_out_data));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_acc_burst();
    int c0;
    c0 = out_count;
    for (int i = 0; i < 4; i++)
      run_cycle(1'b1, {8'd2, 8'd1}, {8'd4, 8'd3}, 1'b1, i == 3, 1'b1, 1'b1);
    drain();
    checks++;
    if (out_count - c0 != 1 || last_out != 44 || last_trunc !== 1'b0) begin
      failures++;
      $display("FAIL acc_burst: outputs=%0d data=%0d trunc=%b, want 1/44/0",
               out_count - c0, last_out, last_trunc);
    end
  endtask

  task automatic test_trunc();
    int c0;
    c0 = out_count;
    for (int i = 0; i < 16; i++)
      run_cycle(1'b1, 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    checks++;
    if (out_count - c0 != 1 || last_out != 32 || last_trunc !== 1'b1) begin
      failures++;
      $display("FAIL trunc_burst: outputs=%0d data=%0d trunc=%b, want 1/32/1",
               out_count - c0, last_out, last_trunc);
    end
    run_cycle(1'b1, 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b1, 16'h0101, 16'h0101, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    checks++;
    if (out_count - c0 != 2 || last_out != 4 || last_trunc !== 1'b0) begin
      failures++;
      $display("FAIL burst_after_trunc: outputs=%0d data=%0d trunc=%b, want 2/4/0",
               out_count - c0, last_out, last_trunc);
    end
  endtask

  task automatic test_back_to_back();
    bit          v, md, lst, ordy, e, pending;
    logic [15:0] a, b;
    pending = 0; md = 0; v = 0; lst = 0; a = '0; b = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        v = ($urandom_range(0, 3) != 0);
        a = 16'($urandom);
        b = 16'($urandom);
        lst = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) md = ~md;
      end
      e = ($urandom_range(0, 7) != 0);
      ordy = e ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cycle(v, a, b, md, lst, ordy, e);
      pending = v && !accepted;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int c0;
    run_cycle(1'b1, 16'h0303, 16'h0505, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b1, 16'h0303, 16'h0505, 1'b1, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    run_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_trunc !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: valid=%b data=%0d trunc=%b, want 0/0/0",
               out_valid, out_data, out_trunc);
    end
    rst = 1'b1;
    c0 = out_count;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL discarded_beats: valid=%b want 0 at idle cycle %0d", out_valid, i);
      end
    end
    run_cycle(1'b1, 16'h0202, 16'h0202, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
    checks++;
    if (out_count - c0 != 1 || last_out != 8 || last_trunc !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_burst: outputs=%0d data=%0d trunc=%b, want 1/8/0",
               out_count - c0, last_out, last_trunc);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; acc_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; s_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_signed();
    test_acc_burst();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
